// File: rtl/oeo_recirc_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oeo_recirc_buffer_pkg
// Purpose  : Shared switch-level types and constants for the OEO
//            recirculation buffer: packet, request and grant records, the
//            recirculated-tag bit position and the buffer FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package oeo_recirc_buffer_pkg;

  localparam int PORTS      = 4;                // switch ports
  localparam int TOF        = 4;                // time of flight, cycles
  localparam int DEST_W     = $clog2(PORTS);
  localparam int DATA_W     = 33;
  localparam int RECIRC_BIT = 32;               // data bit tagging a recirculated packet

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } packet_t;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
  } req_t;

  typedef struct packed {
    logic valid;
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/oeo_recirc_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_packet
// Purpose  : Single-clock packet FIFO with extended-pointer full/empty decode.
// Ports    : clk, rst_n         clock, async active-low reset
//            i_push, i_data    write request and packet
//            i_pop             read request (head advances)
//            o_head            packet at the read pointer
//            o_next_dest       dest of the entry behind the head
//            o_empty, o_full   pointer decodes
//            o_count           entry count
//            o_push_ok         this cycle's push is being accepted
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_packet
  import oeo_recirc_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  packet_t                 i_data,
  input  logic                    i_pop,
  output packet_t                 o_head,
  output logic [DEST_W-1:0]       o_next_dest,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  packet_t       r_mem [DEPTH];
  logic          w_pop_ok;
  logic [AW-1:0] w_rd_nxt;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign o_push_ok = i_push && (!o_full || w_pop_ok);

  assign w_rd_nxt    = r_rd_ptr[AW-1:0] + AW'(1);
  assign o_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign o_next_dest = r_mem[w_rd_nxt].dest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (o_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/oeo_recirc_buffer.sv
`default_nettype none
// ============================================================================
// Module   : oeo_recirc_buffer
// Purpose  : Per-port recirculation buffer. Stores packets diverted by the
//            switch, re-requests arbitration for the head packet and
//            re-injects it once granted.
// Ports    : clk, rst_n     clock, async active-low reset
//            pkt_in         packet from switch buffer output
//            pkt_out        re-injected packet (valid one cycle per send)
//            req_out        arbitration request for the head packet
//            grant_in       grant for the outstanding request
//            empty, full    FIFO status
//            occupancy      FIFO entry count
//            drop           pulse: an incoming packet was lost (FIFO full)
//            drop_count     saturating drop counter
// Revision : 1.0 - initial release
// ============================================================================
module oeo_recirc_buffer
  import oeo_recirc_buffer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  packet_t                 pkt_in,
  output packet_t                 pkt_out,
  output req_t                    req_out,
  input  grant_t                  grant_in,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    drop,
  output logic [15:0]             drop_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int PW = $clog2(DEPTH) + 1;

  state_t            r_state;
  state_t            w_next_state;
  logic [TW-1:0]     r_timer;
  packet_t           w_head;
  logic [DEST_W-1:0] w_next_dest;
  logic [DEST_W-1:0] w_req_dest;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;
  packet_t           r_pkt_out;
  req_t              r_req;
  logic              r_drop;
  logic [15:0]       r_drop_count;

  assign w_pop  = (r_state == ST_SEND);
  assign w_drop = pkt_in.valid && !w_push_ok;

  sync_fifo_packet #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (pkt_in.valid),
    .i_data      (pkt_in),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_next_dest (w_next_dest),
    .o_empty     (empty),
    .o_full      (full),
    .o_count     (occupancy),
    .o_push_ok   (w_push_ok)
  );

  always_comb begin
    w_next_state = r_state;
    w_req_dest   = w_head.dest;
    case (r_state)
      ST_IDLE: if (!empty) w_next_state = ST_REQ;
      ST_REQ:  w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (grant_in.valid)                     w_next_state = ST_SEND;
        else if (r_timer == TW'(TIMEOUT - 1))   w_next_state = ST_REQ;
      end
      ST_SEND: begin
        // The head pops this cycle; the following request targets whatever
        // becomes the new head: the entry behind it, or the packet being
        // pushed right now when the popped entry was the only one.
        if ((occupancy > PW'(1)) || w_push_ok) w_next_state = ST_REQ;
        else                                   w_next_state = ST_IDLE;
        w_req_dest = (occupancy > PW'(1)) ? w_next_dest : pkt_in.dest;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_pkt_out    <= '0;
      r_req        <= '0;
      r_drop       <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_next_state;

      if (r_state == ST_REQ)       r_timer <= '0;
      else if (r_state == ST_WAIT) r_timer <= r_timer + TW'(1);

      // Outputs are registered off the next state so they line up with the
      // cycle the FSM spends in REQ / SEND.
      r_pkt_out <= '0;
      if (w_next_state == ST_SEND) begin
        r_pkt_out       <= w_head;
        r_pkt_out.valid <= 1'b1;
      end

      r_req <= '0;
      if (w_next_state == ST_REQ) begin
        r_req.valid <= 1'b1;
        r_req.dest  <= w_req_dest;
      end

      r_drop <= w_drop;
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign pkt_out    = r_pkt_out;
  assign req_out    = r_req;
  assign drop       = r_drop;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_oeo_recirc_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_oeo_recirc_buffer
// Purpose  : Directed self-checking bench for oeo_recirc_buffer.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_oeo_recirc_buffer;
  import oeo_recirc_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  packet_t     pkt_in;
  packet_t     pkt_out;
  req_t        req_out;
  grant_t      grant_in;
  logic        empty;
  logic        full;
  logic [3:0]  occupancy;
  logic        drop;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  oeo_recirc_buffer #(
    .DEPTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_in     (pkt_in),
    .pkt_out    (pkt_out),
    .req_out    (req_out),
    .grant_in   (grant_in),
    .empty      (empty),
    .full       (full),
    .occupancy  (occupancy),
    .drop       (drop),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic packet_t mk(input logic [1:0] d, input logic [31:0] v);
    packet_t p;
    p.valid = 1'b1;
    p.dest  = d;
    p.data  = {1'b1, v};
    return p;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    pkt_in   = '0;
    grant_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) until req_out.valid is high in the current cycle.
  task automatic wait_req(input string name);
    int n = 0;
    while (!req_out.valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!req_out.valid) begin
      errors++;
      $display("FAIL %s req_out.valid timeout got 0 exp 1", name);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    grant_in = '0;
    pkt_in   = mk(2'd1, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      pkt_in.valid = i[0];
      tick();
      checks++;
      if (pkt_out !== '0 || req_out !== '0 || drop !== 1'b0 || drop_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs got pkt=%0h req=%0h drop=%0b cnt=%0d exp 0", pkt_out, req_out, drop, drop_count);
      end
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || occupancy !== 4'd0) begin
        errors++;
        $display("FAIL reset_status got empty=%0b full=%0b occ=%0d exp 1/0/0", empty, full, occupancy);
      end
    end
    pkt_in = '0;
    rst_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (req_out.valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_req got %0b exp 0", req_out.valid);
      end
    end
  endtask

  task automatic test_single();
    packet_t p;
    do_reset();
    p      = mk(2'd3, 32'hDEAD_BEEF);
    pkt_in = p;                       // cycle 0
    tick();                           // cycle 1
    pkt_in = '0;
    checks++;
    if (occupancy !== 4'd1 || req_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c1 got occ=%0d req=%0b exp 1/0", occupancy, req_out.valid);
    end
    tick();                           // cycle 2
    checks++;
    if (req_out.valid !== 1'b1 || req_out.dest !== 2'd3) begin
      errors++;
      $display("FAIL single_req got v=%0b dest=%0d exp 1/3", req_out.valid, req_out.dest);
    end
    tick();                           // cycle 3
    checks++;
    if (req_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_req_pulse got %0b exp 0", req_out.valid);
    end
    tick();                           // cycle 4
    tick();                           // cycle 5
    grant_in.valid = 1'b1;
    tick();                           // cycle 6
    grant_in.valid = 1'b0;
    checks++;
    if (pkt_out.valid !== 1'b1 || pkt_out.data !== p.data || pkt_out.dest !== 2'd3 ||
        pkt_out.data[RECIRC_BIT] !== 1'b1) begin
      errors++;
      $display("FAIL single_out got %0h exp %0h", pkt_out, p);
    end
    tick();                           // cycle 7
    checks++;
    if (empty !== 1'b1 || pkt_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty got empty=%0b out=%0b exp 1/0", empty, pkt_out.valid);
    end
  endtask

  task automatic test_timeout();
    logic exp_req;
    do_reset();
    pkt_in = mk(2'd1, 32'h1234);      // cycle 0
    tick();                           // cycle 1
    pkt_in = '0;
    for (int c = 1; c <= 37; c++) begin
      exp_req = (c == 2) || (c == 19) || (c == 36);
      checks++;
      if (req_out.valid !== exp_req || occupancy !== 4'd1) begin
        errors++;
        $display("FAIL timeout_c%0d got req=%0b occ=%0d exp %0b/1", c, req_out.valid, occupancy, exp_req);
      end
      if (c < 37) tick();
    end
    grant_in.valid = 1'b1;            // cycle 37, WAIT
    tick();
    grant_in.valid = 1'b0;
    checks++;
    if (pkt_out.valid !== 1'b1 || pkt_out.dest !== 2'd1) begin
      errors++;
      $display("FAIL timeout_out got v=%0b dest=%0d exp 1/1", pkt_out.valid, pkt_out.dest);
    end
    tick();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL timeout_empty got %0b exp 1", empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pkt_in = mk(2'(i % 4), 32'(i));
      tick();                         // cycle i+1
      checks++;
      if (drop !== (i >= 8)) begin
        errors++;
        $display("FAIL overflow_drop_c%0d got %0b exp %0b", i + 1, drop, (i >= 8));
      end
      if (i == 7) begin
        checks++;
        if (full !== 1'b1 || occupancy !== 4'd8) begin
          errors++;
          $display("FAIL overflow_full got full=%0b occ=%0d exp 1/8", full, occupancy);
        end
      end
    end
    pkt_in = '0;
    tick();
    checks++;
    if (drop !== 1'b0 || drop_count !== 16'd2 || occupancy !== 4'd8) begin
      errors++;
      $display("FAIL overflow_count got drop=%0b cnt=%0d occ=%0d exp 0/2/8", drop, drop_count, occupancy);
    end
    for (int k = 0; k < 8; k++) begin
      wait_req("drain_req");
      checks++;
      if (req_out.dest !== 2'(k % 4)) begin
        errors++;
        $display("FAIL drain_dest%0d got %0d exp %0d", k, req_out.dest, k % 4);
      end
      tick();                         // WAIT
      grant_in.valid = 1'b1;
      tick();                         // SEND
      grant_in.valid = 1'b0;
      checks++;
      if (pkt_out.valid !== 1'b1 || pkt_out.data[31:0] !== 32'(k) || pkt_out.data[RECIRC_BIT] !== 1'b1) begin
        errors++;
        $display("FAIL drain_order%0d got v=%0b data=%0h exp 1/%0h", k, pkt_out.valid, pkt_out.data, k);
      end
    end
    tick();
    checks++;
    if (empty !== 1'b1 || occupancy !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty got empty=%0b occ=%0d exp 1/0", empty, occupancy);
    end
  endtask

  task automatic test_full_send_push();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pkt_in = mk(2'(i % 4), 32'(i + 16));
      tick();
    end
    pkt_in = '0;
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL fsp_full got %0b exp 1", full);
    end
    wait_req("fsp_req");
    tick();                           // WAIT
    grant_in.valid = 1'b1;
    tick();                           // SEND, push in same cycle
    grant_in.valid = 1'b0;
    checks++;
    if (pkt_out.valid !== 1'b1 || pkt_out.data[31:0] !== 32'd16) begin
      errors++;
      $display("FAIL fsp_out got v=%0b data=%0h exp 1/10", pkt_out.valid, pkt_out.data);
    end
    pkt_in = mk(2'd2, 32'd99);
    tick();
    pkt_in = '0;
    checks++;
    if (drop !== 1'b0 || occupancy !== 4'd8 || full !== 1'b1 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL fsp_nodrop got drop=%0b occ=%0d full=%0b cnt=%0d exp 0/8/1/0", drop, occupancy, full, drop_count);
    end
    checks++;
    if (req_out.valid !== 1'b1 || req_out.dest !== 2'd1) begin
      errors++;
      $display("FAIL fsp_rereq got v=%0b dest=%0d exp 1/1", req_out.valid, req_out.dest);
    end
  endtask

  task automatic test_stray_and_reset();
    do_reset();
    grant_in.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pkt_out.valid !== 1'b0 || req_out.valid !== 1'b0) begin
        errors++;
        $display("FAIL stray_idle got out=%0b req=%0b exp 0/0", pkt_out.valid, req_out.valid);
      end
    end
    grant_in.valid = 1'b0;
    pkt_in = mk(2'd2, 32'h77);        // cycle 0
    tick();                           // cycle 1, IDLE non-empty
    pkt_in = '0;
    grant_in.valid = 1'b1;
    tick();                           // cycle 2, REQ
    checks++;
    if (req_out.valid !== 1'b1 || pkt_out.valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_req got req=%0b out=%0b exp 1/0", req_out.valid, pkt_out.valid);
    end
    tick();                           // cycle 3, WAIT
    grant_in.valid = 1'b0;
    checks++;
    if (pkt_out.valid !== 1'b0 || occupancy !== 4'd1) begin
      errors++;
      $display("FAIL stray_ignored got out=%0b occ=%0d exp 0/1", pkt_out.valid, occupancy);
    end
    tick();                           // cycle 4, WAIT
    rst_n = 1'b0;
    grant_in.valid = 1'b1;
    #1;
    checks++;
    if (pkt_out !== '0 || req_out !== '0 || occupancy !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wait_reset got out=%0h req=%0h occ=%0d empty=%0b exp 0/0/0/1", pkt_out, req_out, occupancy, empty);
    end
    tick();
    tick();
    rst_n = 1'b1;
    grant_in.valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (pkt_out.valid !== 1'b0 || occupancy !== 4'd0) begin
        errors++;
        $display("FAIL post_reset got out=%0b occ=%0d exp 0/0", pkt_out.valid, occupancy);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pkt_in   = '0;
    grant_in = '0;
    test_reset();
    test_single();
    test_timeout();
    test_overflow();
    test_full_send_push();
    test_stray_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
